// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared definitions for the 8-puzzle replay path.
//   - board geometry (tile/position widths, packed board width)
//   - blank-move encoding MV_UP/MV_DOWN/MV_LEFT/MV_RIGHT
//   - replay FSM state encoding
//   - GOAL_BOARD (1..8 row-major, blank last) and find_blank() helper
package puzzle_pkg;

  localparam int TILE_W    = 4;
  localparam int NUM_TILES = 9;
  localparam int BOARD_W   = TILE_W * NUM_TILES;
  localparam int POS_W     = 4;

  localparam logic [1:0] MV_UP    = 2'd0;
  localparam logic [1:0] MV_DOWN  = 2'd1;
  localparam logic [1:0] MV_LEFT  = 2'd2;
  localparam logic [1:0] MV_RIGHT = 2'd3;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RECORD   = 3'd1;
  localparam state_t ST_READY    = 3'd2;
  localparam state_t ST_APPLY    = 3'd3;
  localparam state_t ST_FINISHED = 3'd4;

  // Tile i lives at [4i+3:4i]; tile 0 is the top-left corner.
  localparam logic [BOARD_W-1:0] GOAL_BOARD = 36'h0_8765_4321;

  // Lowest position holding the blank tile, 0 when the board has none.
  function automatic logic [POS_W-1:0] find_blank(input logic [BOARD_W-1:0] b);
    logic [POS_W-1:0] pos;
    pos = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (b[i*TILE_W +: TILE_W] == '0) pos = POS_W'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/puzzle_replay_ctrl_btn_pulse.sv
// btn_pulse: raw push button -> single-cycle press pulse.
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn          : raw button, asynchronous to clk
//   pulse        : one-cycle pulse once the synced level has stayed high
//                  for DEBOUNCE_CYC cycles; nothing on release
module btn_pulse #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = sync2_q;
    cnt_d   = cnt_q;
    // Any edge on the synced level restarts the stability count; the count
    // saturates so a held button fires exactly once.
    if (sync2_q != level_q) cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  assign pulse = sync2_q & (sync2_q == level_q) & (cnt_q == CNT_FIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/puzzle_replay_ctrl.sv
// puzzle_replay_ctrl: records the solver's move list and replays it one
// move per debounced button press.
//   load/board_in            : capture start board, restart recording
//   mv_valid/mv_data/mv_last : solver move stream, mv_ready handshake
//   btn                      : raw step button
//   board/step/total         : current board, moves applied, moves recorded
//   solved/finished/err      : goal reached, replay done, sticky error
module puzzle_replay_ctrl
  import puzzle_pkg::*;
#(
  parameter int MAX_MOVES    = 32,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn,
  input  logic                         load,
  input  logic [35:0]                  board_in,
  input  logic                         mv_valid,
  input  logic [1:0]                   mv_data,
  input  logic                         mv_last,
  output logic                         mv_ready,
  output logic [35:0]                  board,
  output logic [$clog2(MAX_MOVES):0]   step,
  output logic [$clog2(MAX_MOVES):0]   total,
  output logic                         solved,
  output logic                         finished,
  output logic                         err
);

  localparam int AW = $clog2(MAX_MOVES);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_MOVES);

  state_t             state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [POS_W-1:0]   blank_q, blank_d;
  logic [CW-1:0]      step_q, step_d;
  logic [CW-1:0]      total_q, total_d;
  logic               err_q, err_d;

  logic [1:0]         mv_buf_q [MAX_MOVES];

  logic               press;
  logic               hs;
  logic [1:0]         cur_mv;
  logic [POS_W-1:0]   col;
  logic [POS_W-1:0]   tgt;
  logic               legal;
  logic [TILE_W-1:0]  blank_tile, tgt_tile;
  logic [BOARD_W-1:0] swap_board;

  btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .pulse (press)
  );

  assign mv_ready = (state_q == ST_RECORD) && (total_q < MAX_CNT);
  assign hs       = mv_valid & mv_ready;

  // Move buffer has no reset: only entries below total are ever read.
  always_ff @(posedge clk) begin
    if (hs && !load) mv_buf_q[total_q[AW-1:0]] <= mv_data;
  end

  // Next move decode, target position and the swapped board.
  always_comb begin
    cur_mv = mv_buf_q[step_q[AW-1:0]];
    col    = blank_q % POS_W'(3);
    tgt    = blank_q;
    legal  = 1'b0;
    case (cur_mv)
      MV_UP:    begin tgt = blank_q - POS_W'(3); legal = (blank_q >= POS_W'(3)); end
      MV_DOWN:  begin tgt = blank_q + POS_W'(3); legal = (blank_q <= POS_W'(5)); end
      MV_LEFT:  begin tgt = blank_q - POS_W'(1); legal = (col != POS_W'(0)); end
      default:  begin tgt = blank_q + POS_W'(1); legal = (col != POS_W'(2)); end
    endcase
    blank_tile = '0;
    tgt_tile   = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (POS_W'(i) == blank_q) blank_tile = board_q[i*TILE_W +: TILE_W];
      if (POS_W'(i) == tgt)     tgt_tile   = board_q[i*TILE_W +: TILE_W];
    end
    swap_board = board_q;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (POS_W'(i) == blank_q) swap_board[i*TILE_W +: TILE_W] = tgt_tile;
      if (POS_W'(i) == tgt)     swap_board[i*TILE_W +: TILE_W] = blank_tile;
    end
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    blank_d = blank_q;
    step_d  = step_q;
    total_d = total_q;
    err_d   = err_q;
    if (load) begin
      // load overrides everything, including a move being applied
      board_d = board_in;
      blank_d = find_blank(board_in);
      step_d  = '0;
      total_d = '0;
      err_d   = 1'b0;
      state_d = ST_RECORD;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RECORD: begin
          if (hs) begin
            total_d = total_q + 1'b1;
            if (mv_last) state_d = ST_READY;
          end else if (mv_valid && (total_q == MAX_CNT)) begin
            err_d   = 1'b1;
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (step_q == total_q) state_d = ST_FINISHED;
          else if (press) state_d = ST_APPLY;
        end
        ST_APPLY: begin
          if (legal) begin
            board_d = swap_board;
            blank_d = tgt;
          end else begin
            err_d = 1'b1;
          end
          step_d  = step_q + 1'b1;
          state_d = ST_READY;
        end
        ST_FINISHED: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      board_q <= '0;
      blank_q <= '0;
      step_q  <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      blank_q <= blank_d;
      step_q  <= step_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  assign board    = board_q;
  assign step     = step_q;
  assign total    = total_q;
  assign solved   = (board_q == GOAL_BOARD);
  assign finished = (state_q == ST_FINISHED);
  assign err      = err_q;

endmodule
